mlp_mul_arbiter: RTL and testbench

Shares one pipelined signed 16x27 multiplier (mlp_mul_mul_16s_27s_43_4_1) between NUM_REQ MLP datapath requesters.
- Round-robin arbitration of operand requests.
- A valid/tag shadow pipeline tracks each in-flight product so every result returns tagged with its requester ID.
- Stalls the multiplier through its ce input under output backpressure.
- Sits between the neuron lanes and the shared multiplier instance.

---
 rtl/mlp_mul_arb_pkg.sv | 15 +
 rtl/mlp_rr_arbiter.sv | 45 ++++
 rtl/mlp_mul_arbiter.sv | 82 ++++++++
 tb/tb_mlp_mul_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_mul_arb_pkg.sv
// Shared definitions for the MLP multiplier arbiter: default operand/product widths,
// multiplier latency and the requester tag-width helper.
package mlp_mul_arb_pkg;

    localparam int unsigned AW_DEF      = 16;
    localparam int unsigned BW_DEF      = 27;
    localparam int unsigned PW_DEF      = 43;
    localparam int unsigned MUL_LAT_DEF = 3;

    // A single requester still needs a 1-bit tag field.
    function automatic int unsigned tag_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mlp_rr_arbiter.sv
// Rotating-priority arbiter: combinational one-hot grant searched from pointer+1 with
// wrap, gated by en_i; the pointer moves to the winner whenever a grant is issued.
module mlp_rr_arbiter
    import mlp_mul_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    localparam int unsigned TW = tag_width(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [TW-1:0] gnt_idx_o
);

    logic [TW-1:0] ptr_q;
    logic [TW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = TW'((32'(ptr_q) + k) % N);
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

    // Reset to the last index so requester 0 wins the first arbitration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= TW'(N - 1);
        end else if (found) begin
            ptr_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/mlp_mul_arbiter.sv
// Shares one pipelined signed multiplier between NUM_REQ requesters; a valid/tag shadow
// pipeline returns each product tagged with its issuer, stalling via ce on backpressure.
module mlp_mul_arbiter
    import mlp_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned A_W     = AW_DEF,
    parameter int unsigned B_W     = BW_DEF,
    parameter int unsigned P_W     = PW_DEF,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    localparam int unsigned TAG_W  = tag_width(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [P_W-1:0]         rsp_data,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   mul_ce,
    output logic [A_W-1:0]         mul_din0,
    output logic [B_W-1:0]         mul_din1,
    input  logic [P_W-1:0]         mul_dout,
    output logic                   busy
);

    logic [NUM_REQ-1:0]            gnt;
    logic [TAG_W-1:0]              gnt_idx;
    logic                          gnt_any;
    logic                          arb_en;
    logic [MUL_LAT-1:0]            vld_sr_q;
    logic [MUL_LAT-1:0][TAG_W-1:0] tag_sr_q;

    // Only a valid, unaccepted product at the head freezes the pipe; bubbles collapse.
    assign mul_ce  = !(vld_sr_q[MUL_LAT-1] && !rsp_ready);
    // No grants while reset is held, so nothing is accepted only to be dropped.
    assign arb_en  = mul_ce && reset_n;
    assign gnt_any = |gnt;

    mlp_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .en_i      (arb_en),
        .req_i     (req_valid),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready = gnt;

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mul_din0 = req_a[i*A_W +: A_W];
                mul_din1 = req_b[i*B_W +: B_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr_q <= '0;
            tag_sr_q <= '0;
        end else if (mul_ce) begin
            vld_sr_q <= {vld_sr_q[MUL_LAT-2:0], gnt_any};
            tag_sr_q <= {tag_sr_q[MUL_LAT-2:0], gnt_idx};
        end
    end

    assign rsp_valid = vld_sr_q[MUL_LAT-1];
    assign rsp_tag   = tag_sr_q[MUL_LAT-1];
    assign rsp_data  = mul_dout;
    assign busy      = |vld_sr_q;

endmodule

// File: tb/tb_mlp_mul_arbiter.sv
// Bench for mlp_mul_arbiter: behavioural multiplier, queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mlp_mul_arbiter;

    localparam int NR  = 4;
    localparam int A_W = 16;
    localparam int B_W = 27;
    localparam int P_W = 43;
    localparam int ML  = 3;
    localparam int TW  = 2;

    logic                    clk     = 1'b0;
    logic                    reset_n = 1'b1;
    logic [NR-1:0]           req_valid;
    logic [NR-1:0]           req_ready;
    logic [NR*A_W-1:0]       req_a;
    logic [NR*B_W-1:0]       req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic signed [P_W-1:0]   rsp_data;
    logic [TW-1:0]           rsp_tag;
    logic                    mul_ce;
    logic signed [A_W-1:0]   mul_din0;
    logic signed [B_W-1:0]   mul_din1;
    logic signed [P_W-1:0]   mul_dout;
    logic                    busy;

    logic signed [A_W-1:0]   a_arr [NR];
    logic signed [B_W-1:0]   b_arr [NR];

    int total = 0;
    int bad   = 0;

    typedef struct {int tag; longint prod; int age;} item_t;
    typedef struct {int tag; longint data;} rsp_t;
    item_t mq[$];
    rsp_t  log_q[$];
    int    acc_cnt = 0;
    int    last_g  = NR - 1;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_a[i*A_W +: A_W] = a_arr[i];
            req_b[i*B_W +: B_W] = b_arr[i];
        end
    end

    // Behavioural stand-in for the shared 4-stage multiplier (3 ce-enabled edges).
    logic signed [P_W-1:0] m_q [ML];
    always @(posedge clk) begin
        if (mul_ce) begin
            m_q[0] <= P_W'(mul_din0) * P_W'(mul_din1);
            for (int i = 1; i < ML; i++) m_q[i] <= m_q[i-1];
        end
    end
    assign mul_dout = m_q[ML-1];

    mlp_mul_arbiter #(
        .NUM_REQ (NR),
        .A_W     (A_W),
        .B_W     (B_W),
        .P_W     (P_W),
        .MUL_LAT (ML)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .busy      (busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference model: in-flight items age on every ce edge; an item of age ML is at the head.
    initial begin : model
        item_t  it;
        bit     head_rdy, e_ce, p_ce, p_pop;
        int     g, p_g;
        longint p_prod;
        p_ce = 1'b0; p_pop = 1'b0; p_g = -1; p_prod = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mq.delete();
                last_g = NR - 1;
                p_ce   = 1'b0;
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_req_ready", req_ready, 0);
                check("rst_mul_ce", mul_ce, 1);
            end else begin
                head_rdy = (mq.size() > 0) && (mq[0].age == ML);
                e_ce     = !(head_rdy && !rsp_ready);
                g        = -1;
                if (e_ce) begin
                    for (int k = 1; k <= NR; k++) begin
                        if (g < 0 && req_valid[(last_g + k) % NR]) g = (last_g + k) % NR;
                    end
                end
                check("mul_ce", mul_ce, e_ce);
                check("req_ready", req_ready, (g < 0) ? 0 : (longint'(1) << g));
                check("mul_din0", mul_din0, (g < 0) ? 0 : longint'(a_arr[g]));
                check("mul_din1", mul_din1, (g < 0) ? 0 : longint'(b_arr[g]));
                check("rsp_valid", rsp_valid, head_rdy);
                check("busy", busy, mq.size() > 0);
                if (head_rdy) begin
                    check("rsp_tag", rsp_tag, mq[0].tag);
                    check("rsp_data", rsp_data, mq[0].prod);
                end
                if (rsp_valid && rsp_ready) log_q.push_back('{int'(rsp_tag), longint'(rsp_data)});
                if (|(req_valid & req_ready)) acc_cnt++;
                p_ce   = e_ce;
                p_pop  = head_rdy && rsp_ready;
                p_g    = g;
                p_prod = (g < 0) ? 0 : longint'(a_arr[g]) * longint'(b_arr[g]);
            end
            @(posedge clk);
            if (p_ce) begin
                if (p_pop) void'(mq.pop_front());
                foreach (mq[i]) mq[i].age++;
                if (p_g >= 0) begin
                    it.tag  = p_g;
                    it.prod = p_prod;
                    it.age  = 1;
                    mq.push_back(it);
                    last_g = p_g;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset_n   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            tick();
        end
        check("drain_idle", busy, 0);
    endtask

    longint held_d;
    int     held_t;

    initial begin
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
        #1 reset_n = 1'b0;
        #1;
        check("init_rsp_valid", rsp_valid, 0);
        check("init_busy", busy, 0);
        check("init_req_ready", req_ready, 0);
        check("init_mul_ce", mul_ce, 1);
        do_reset();

        // 1: single request from requester 2
        a_arr[2] = -16'sd2; b_arr[2] = 27'sd100000; req_valid = 4'b0100;
        @(negedge clk);
        check("t1_req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_data", rsp_data, -200000);
        check("t1_rsp_tag", rsp_tag, 2);
        tick();
        @(negedge clk);
        check("t1_busy_low", busy, 0);
        tick();

        // 2: all requesters valid, round-robin streaming
        do_reset();
        log_q.delete();
        for (int i = 0; i < NR; i++) begin a_arr[i] = A_W'(i + 1); b_arr[i] = 27'sd10; end
        req_valid = '1;
        repeat (12) tick();
        drain();
        check("t2_count", log_q.size(), 12);
        for (int k = 0; k < 8 && k < log_q.size(); k++) begin
            check("t2_tag", log_q[k].tag, k % 4);
            check("t2_data", log_q[k].data, 10 * (k % 4 + 1));
        end

        // 3: operand extremes
        log_q.delete();
        a_arr[0] = -16'sd32768; b_arr[0] = -27'sd67108864; req_valid = 4'b0001;
        tick();
        a_arr[0] = 16'sd32767;
        tick();
        drain();
        check("t3_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t3_min_min", log_q[0].data, 64'sd2199023255552);
            check("t3_max_min", log_q[1].data, -64'sd2198956146688);
        end

        // 4: backpressure on a stream from requester 1
        log_q.delete();
        acc_cnt   = 0;
        req_valid = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            a_arr[1] = A_W'($urandom); b_arr[1] = B_W'($urandom);
            tick();
            if (rsp_valid) break;
        end
        check("t4_first_rsp", rsp_valid, 1);
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin held_d = rsp_data; held_t = int'(rsp_tag); end
            check("t4_ce_low", mul_ce, 0);
            check("t4_ready_low", req_ready, 0);
            check("t4_data_hold", rsp_data, held_d);
            check("t4_tag_hold", rsp_tag, held_t);
            tick();
            a_arr[1] = A_W'($urandom);
        end
        rsp_ready = 1'b1;
        repeat (4) begin a_arr[1] = A_W'($urandom); b_arr[1] = B_W'($urandom); tick(); end
        drain();
        check("t4_no_loss", log_q.size(), acc_cnt);

        // 5: bubble collapse with rsp_ready low
        do_reset();
        log_q.delete();
        rsp_ready = 1'b0;
        a_arr[0] = 16'sd3; b_arr[0] = 27'sd5; req_valid = 4'b0001;
        tick();
        a_arr[3] = 16'sd7; b_arr[3] = 27'sd2; req_valid = 4'b1000;
        @(negedge clk);
        check("t5_ce_a", mul_ce, 1);
        check("t5_gnt_a", req_ready, 4'b1000);
        tick();
        @(negedge clk);
        check("t5_ce_b", mul_ce, 1);
        check("t5_gnt_b", req_ready, 4'b1000);
        tick();
        @(negedge clk);
        check("t5_ce_stall", mul_ce, 0);
        check("t5_gnt_stall", req_ready, 0);
        tick();
        drain();
        check("t5_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("t5_first", log_q[0].data, 15);
            check("t5_second", log_q[1].data, 14);
        end

        // 6: reset with products in flight, then arbitration restarts from requester 0
        do_reset();
        rsp_ready = 1'b1;
        req_valid = '1;
        repeat (3) tick();
        reset_n   = 1'b0;
        req_valid = '0;
        #1;
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_busy", busy, 0);
        tick();
        tick();
        reset_n   = 1'b1;
        req_valid = 4'b1000;
        @(negedge clk);
        check("t6_gnt3", req_ready, 4'b1000);
        tick();
        req_valid = 4'b1001;
        @(negedge clk);
        check("t6_gnt0", req_ready, 4'b0001);
        tick();
        drain();

        // Randomized traffic and backpressure
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                a_arr[i] = A_W'($urandom);
                b_arr[i] = B_W'($urandom);
            end
            rsp_ready = ($urandom % 4) != 0;
            tick();
        end
        drain();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
